// File: rtl/regbank_sequencer.sv
// regbank_sequencer
//   Controller for the A/B/C load-register and output-mux datapath.
//   Load commands (op 00/01/10) latch cmd_data into data_a/b/c and pulse the
//   matching ld_x for LD_PULSE cycles. A dump command (op 11) walks
//   output_sel through 00, 01, 10. For each step it waits SETTLE_CYCLES,
//   captures dp_data_in and hands the word out on a valid/ready port,
//   tagged with its source.
//
//   Optional feature macro: SEQ_READBACK_EN
//     When defined, each load is followed by a VERIFY window. In that window
//     the loaded register is selected and read back. Any mismatch sets the
//     sticky output rb_err.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_op, cmd_data carry the command
//   ld_a, ld_b, ld_c    datapath load enables
//   data_a/b/c          datapath load data
//   output_sel          datapath mux select (11 = idle / nothing selected)
//   dp_data_in          datapath data_out feedback
//   out_valid/ready     dump word handshake; out_data, out_tag carry the word
//   busy                controller not idle
//   rb_err              readback mismatch seen (SEQ_READBACK_EN only)
module regbank_sequencer #(
  parameter int LD_PULSE      = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        ld_a,
  output logic        ld_b,
  output logic        ld_c,
  output logic [7:0]  data_a,
  output logic [7:0]  data_b,
  output logic [15:0] data_c,
  output logic [1:0]  output_sel,
  input  logic [15:0] dp_data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_tag,
`ifdef SEQ_READBACK_EN
  output logic        rb_err,
`endif
  output logic        busy
);

  localparam int MAX_CNT = (LD_PULSE > SETTLE_CYCLES) ? LD_PULSE : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] LD_LAST  = CNT_W'(LD_PULSE - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

`ifdef SEQ_READBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEL, S_WAIT_OUT, S_VERIFY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEL, S_WAIT_OUT} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [2:0]         ld_q, ld_d;            // {c, b, a}
  logic [7:0]         data_a_q, data_a_d;
  logic [7:0]         data_b_q, data_b_d;
  logic [15:0]        data_c_q, data_c_d;
  logic [1:0]         sel_q, sel_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        out_data_q, out_data_d;
  logic [1:0]         out_tag_q, out_tag_d;
  logic               busy_q, busy_d;
`ifdef SEQ_READBACK_EN
  logic               rb_err_q, rb_err_d;
  logic [15:0]        rb_expect;

  // Value the datapath should present for the register being verified.
  always_comb begin
    rb_expect = 16'h0000;
    case (sel_q)
      2'b00:   rb_expect = {8'h00, data_a_q};
      2'b01:   rb_expect = {8'h00, data_b_q};
      2'b10:   rb_expect = data_c_q;
      default: rb_expect = 16'h0000;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      ld_q        <= 3'b000;
      data_a_q    <= 8'h00;
      data_b_q    <= 8'h00;
      data_c_q    <= 16'h0000;
      sel_q       <= 2'b11;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_tag_q   <= 2'b00;
      busy_q      <= 1'b0;
`ifdef SEQ_READBACK_EN
      rb_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      ld_q        <= ld_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      data_c_q    <= data_c_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      busy_q      <= busy_d;
`ifdef SEQ_READBACK_EN
      rb_err_q    <= rb_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    ld_d        = ld_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    data_c_d    = data_c_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
`ifdef SEQ_READBACK_EN
    rb_err_d    = rb_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        // cmd_ready comes up one edge after reset release and stays up here.
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          if (cmd_op == 2'b11) begin
            sel_d   = 2'b00;
            state_d = S_SEL;
          end else begin
            ld_d    = 3'b001 << cmd_op;
            state_d = S_LOAD;
            case (cmd_op)
              2'b00:   data_a_d = cmd_data[7:0];
              2'b01:   data_b_d = cmd_data[7:0];
              default: data_c_d = cmd_data;
            endcase
          end
        end
      end

      S_LOAD: begin
        if (cnt_q == LD_LAST) begin
          ld_d = 3'b000;
`ifdef SEQ_READBACK_EN
          // ld_q is still one-hot here, so it names the register to read back.
          sel_d   = {ld_q[2], ld_q[1]};
          cnt_d   = '0;
          state_d = S_VERIFY;
`else
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef SEQ_READBACK_EN
      S_VERIFY: begin
        if (cnt_q == SET_LAST) begin
          if (dp_data_in != rb_expect) rb_err_d = 1'b1;
          sel_d       = 2'b11;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      S_SEL: begin
        if (cnt_q == SET_LAST) begin
          out_data_d  = dp_data_in;
          out_tag_d   = sel_q;
          out_valid_d = 1'b1;
          state_d     = S_WAIT_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (sel_q == 2'b10) begin
            sel_d       = 2'b11;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            sel_d   = sel_q + 2'd1;
            cnt_d   = '0;
            state_d = S_SEL;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign cmd_ready  = cmd_ready_q;
  assign ld_a       = ld_q[0];
  assign ld_b       = ld_q[1];
  assign ld_c       = ld_q[2];
  assign data_a     = data_a_q;
  assign data_b     = data_b_q;
  assign data_c     = data_c_q;
  assign output_sel = sel_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign busy       = busy_q;
`ifdef SEQ_READBACK_EN
  assign rb_err     = rb_err_q;
`endif

endmodule

// File: tb/tb_regbank_sequencer.sv
// Testbench for regbank_sequencer: directed steps plus random load/dump
// commands against a register-content model and formula-based timing.
module tb_regbank_sequencer;
  localparam int LDP = 1;
  localparam int STL = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        ld_a, ld_b, ld_c;
  logic [7:0]  data_a, data_b;
  logic [15:0] data_c;
  logic [1:0]  output_sel;
  logic [15:0] dp_data_in;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_tag;
  logic        busy;
`ifdef SEQ_READBACK_EN
  logic        rb_err;
`endif

  always #5 clk = ~clk;

  regbank_sequencer #(.LD_PULSE(LDP), .SETTLE_CYCLES(STL)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c),
    .data_a(data_a), .data_b(data_b), .data_c(data_c),
    .output_sel(output_sel), .dp_data_in(dp_data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
`ifdef SEQ_READBACK_EN
    .rb_err(rb_err),
`endif
    .busy(busy)
  );

  // Datapath model: latches keep their contents across controller reset.
  logic [7:0]  dp_a = 8'h00, dp_b = 8'h00;
  logic [15:0] dp_c = 16'h0000;
  bit          dp_corrupt = 1'b0;
  always @(posedge clk) begin
    if (ld_a) dp_a <= data_a;
    if (ld_b) dp_b <= data_b;
    if (ld_c) dp_c <= data_c;
  end
  always_comb begin
    dp_data_in = 16'h0000;
    case (output_sel)
      2'b00:   dp_data_in = {8'h00, dp_a};
      2'b01:   dp_data_in = {8'h00, dp_b};
      2'b10:   dp_data_in = dp_corrupt ? 16'h0000 : dp_c;
      default: dp_data_in = 16'h0000;
    endcase
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] regq [3];   // expected controller data_a/b/c
  logic [15:0] dpm  [3];   // expected datapath register contents

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_data();
    chk("data_a", {8'h00, data_a}, regq[0]);
    chk("data_b", {8'h00, data_b}, regq[1]);
    chk("data_c", data_c, regq[2]);
  endtask

  // Entered and left just after a falling edge.
  task automatic do_load(input logic [1:0] op, input logic [15:0] d);
    int w;
    logic [2:0] onehot;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    chk("load accept ready", {15'd0, cmd_ready}, 16'd1);
    regq[op] = (op == 2'b10) ? d : {8'h00, d[7:0]};
    dpm[op]  = regq[op];
    onehot   = 3'b001 << op;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 16'($urandom);
    for (int i = 0; i < LDP; i++) begin
      chk("ld pulse", {13'd0, ld_c, ld_b, ld_a}, {13'd0, onehot});
      chk("load ready low", {15'd0, cmd_ready}, 16'd0);
      chk("load busy", {15'd0, busy}, 16'd1);
      chk_data();
      @(negedge clk);
    end
`ifdef SEQ_READBACK_EN
    for (int i = 0; i < STL; i++) begin
      chk("verify ld off", {13'd0, ld_c, ld_b, ld_a}, 16'd0);
      chk("verify sel", {14'd0, output_sel}, {14'd0, op});
      chk("verify ready low", {15'd0, cmd_ready}, 16'd0);
      @(negedge clk);
    end
`endif
    chk("load end ld off", {13'd0, ld_c, ld_b, ld_a}, 16'd0);
    chk("load end ready", {15'd0, cmd_ready}, 16'd1);
    chk("load end busy", {15'd0, busy}, 16'd0);
    chk("load end sel", {14'd0, output_sel}, 16'd3);
    chk_data();
  endtask

  // stall[k] = cycles out_ready is held low on word k; abort resets on word B.
  task automatic do_dump(input int s0, input int s1, input int s2, input bit abort);
    int w, n;
    int stall [3];
    stall[0] = s0; stall[1] = s1; stall[2] = s2;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 16'($urandom);
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    chk("dump accept ready", {15'd0, cmd_ready}, 16'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("dump busy", {15'd0, busy}, 16'd1);
    chk("dump ready low", {15'd0, cmd_ready}, 16'd0);
    for (int k = 0; k < 3; k++) begin
      n = 1;
      while (!out_valid && n < 40) begin
        chk("sel during settle", {14'd0, output_sel}, 16'(k));
        out_ready = 1'($urandom);
        @(negedge clk); n++;
      end
      chk("valid latency", 16'(n), 16'(STL + 1));
      chk("word data", out_data, dpm[k]);
      chk("word tag", {14'd0, out_tag}, 16'(k));
      chk("word sel", {14'd0, output_sel}, 16'(k));
      if (abort && k == 1) begin
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort out_valid", {15'd0, out_valid}, 16'd0);
        chk("abort sel", {14'd0, output_sel}, 16'd3);
        chk("abort ready", {15'd0, cmd_ready}, 16'd0);
        chk("abort busy", {15'd0, busy}, 16'd0);
        chk("abort out_data", out_data, 16'd0);
        chk("abort data_a", {8'h00, data_a}, 16'd0);
        for (int r = 0; r < 3; r++) regq[r] = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      for (int s = 0; s < stall[k]; s++) begin
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall valid", {15'd0, out_valid}, 16'd1);
        chk("stall data", out_data, dpm[k]);
        chk("stall tag", {14'd0, out_tag}, 16'(k));
        chk("stall sel", {14'd0, output_sel}, 16'(k));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("after xfer valid", {15'd0, out_valid}, 16'd0);
      chk("after xfer sel", {14'd0, output_sel}, (k < 2) ? 16'(k + 1) : 16'd3);
    end
    chk("dump end ready", {15'd0, cmd_ready}, 16'd1);
    chk("dump end busy", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 16'h0000; out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin regq[r] = 16'h0000; dpm[r] = 16'h0000; end
    repeat (2) @(negedge clk);
    chk("reset ready", {15'd0, cmd_ready}, 16'd0);
    chk("reset sel", {14'd0, output_sel}, 16'd3);
    chk("reset out_valid", {15'd0, out_valid}, 16'd0);
    chk("reset ld", {13'd0, ld_c, ld_b, ld_a}, 16'd0);
    chk("reset busy", {15'd0, busy}, 16'd0);
    chk("reset out_tag", {14'd0, out_tag}, 16'd0);
    chk_data();
`ifdef SEQ_READBACK_EN
    chk("reset rb_err", {15'd0, rb_err}, 16'd0);
`endif
    rst = 1'b0;
    #1 chk("ready before edge", {15'd0, cmd_ready}, 16'd0);
    @(negedge clk);
    chk("ready after release", {15'd0, cmd_ready}, 16'd1);

    do_load(2'b00, 16'hFF3C);
    do_load(2'b01, 16'hFFA5);
    do_load(2'b10, 16'hBEEF);
    do_dump(0, 0, 0, 1'b0);
    do_dump(0, 5, 0, 1'b0);
    do_dump(1, 0, 0, 1'b1);
    do_dump(0, 0, 2, 1'b0);

    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b11) do_dump($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      else do_load(op, 16'($urandom));
    end
    do_dump(0, 0, 0, 1'b0);

`ifdef SEQ_READBACK_EN
    chk("rb_err clean", {15'd0, rb_err}, 16'd0);
    dp_corrupt = 1'b1;
    do_load(2'b10, 16'h1234);
    dp_corrupt = 1'b0;
    chk("rb_err set", {15'd0, rb_err}, 16'd1);
    do_load(2'b00, 16'h0055);
    chk("rb_err sticky", {15'd0, rb_err}, 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
